lfsr_rewind: RTL and testbench

Galois LFSR that can step forward or backward, and can seek backward to a target value while counting the steps. It is the reverse-direction companion to the game's pseudo-random generator. It lets game logic replay or undo random draws, for example to restore the alien-fire sequence after a pause or a replay. It also lets game logic measure how many draws ago a given value was produced.

---
 rtl/lfsr_pkg.sv | 37 +++
 rtl/lfsr_seek_ctrl.sv | 111 +++++++++++
 rtl/lfsr_rewind.sv | 87 ++++++++
 tb/tb_lfsr_rewind.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: default taps, width helper, and the forward/backward
// step functions used by both the generator and the rewind block.
package lfsr_pkg;

    localparam int          LFSR_MAXW         = 32;
    localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

    typedef enum logic {
        SEEK_IDLE = 1'b0,
        SEEK_RUN  = 1'b1
    } seek_st_e;

    function automatic int lfsr_dw(input int limit);
        return $clog2(limit + 1);
    endfunction

    // Values are carried at LFSR_MAXW bits with the unused upper bits zero,
    // so one definition serves any LEN up to LFSR_MAXW.
    function automatic logic [LFSR_MAXW-1:0] lfsr_fwd(input logic [LFSR_MAXW-1:0] s,
                                                      input logic [LFSR_MAXW-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

    // Inverse of lfsr_fwd; requires taps[len-1] == 1.
    function automatic logic [LFSR_MAXW-1:0] lfsr_back(input logic [LFSR_MAXW-1:0] n,
                                                       input logic [LFSR_MAXW-1:0] taps,
                                                       input int                   len);
        logic                 b;
        logic [LFSR_MAXW-1:0] x;
        logic [LFSR_MAXW-1:0] mask;
        b    = n[len-1];
        x    = n ^ (b ? taps : '0);
        mask = (len >= LFSR_MAXW) ? '1 : ((LFSR_MAXW'(1) << len) - LFSR_MAXW'(1));
        return ((x << 1) | LFSR_MAXW'(b)) & mask;
    endfunction

endpackage

// File: rtl/lfsr_seek_ctrl.sv
// Backward-seek controller: walks the LFSR back toward a latched target,
// counting steps, and restores the starting value if the limit is reached.
module lfsr_seek_ctrl
    import lfsr_pkg::*;
#(
    parameter int LEN        = 16,
    parameter int SEEK_LIMIT = 2**LEN - 1,
    parameter int DW         = lfsr_dw(SEEK_LIMIT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           seek_start,
    input  logic [LEN-1:0] seek_target,
    input  logic [LEN-1:0] state_q,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [DW-1:0]  distance,
    output logic           seek_step,
    output logic           seek_restore,
    output logic [LEN-1:0] origin,
    output seek_st_e       st
);

    localparam logic [DW-1:0] LIMIT = DW'(SEEK_LIMIT);

    seek_st_e       st_q, st_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  dist_q, dist_d;
    logic [LEN-1:0] target_q, target_d;
    logic [LEN-1:0] origin_q, origin_d;
    logic           done_q, done_d;
    logic           found_q, found_d;

    always_comb begin
        st_d         = st_q;
        cnt_d        = cnt_q;
        dist_d       = dist_q;
        target_d     = target_q;
        origin_d     = origin_q;
        done_d       = 1'b0;
        found_d      = found_q;
        seek_step    = 1'b0;
        seek_restore = 1'b0;
        case (st_q)
            SEEK_IDLE: begin
                if (load) begin
                    found_d = 1'b0;
                end else if (seek_start) begin
                    st_d     = SEEK_RUN;
                    target_d = seek_target;
                    origin_d = state_q;
                    cnt_d    = '0;
                    found_d  = 1'b0;
                end
            end
            SEEK_RUN: begin
                // A hit is tested before the limit so a target exactly
                // SEEK_LIMIT steps back is still reported as found.
                if (load) begin
                    st_d    = SEEK_IDLE;
                    found_d = 1'b0;
                end else if (state_q == target_q) begin
                    st_d    = SEEK_IDLE;
                    done_d  = 1'b1;
                    found_d = 1'b1;
                    dist_d  = cnt_q;
                end else if (cnt_q == LIMIT) begin
                    st_d         = SEEK_IDLE;
                    done_d       = 1'b1;
                    found_d      = 1'b0;
                    dist_d       = cnt_q;
                    seek_restore = 1'b1;
                end else begin
                    seek_step = 1'b1;
                    cnt_d     = cnt_q + DW'(1);
                end
            end
            default: st_d = SEEK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q     <= SEEK_IDLE;
            cnt_q    <= '0;
            dist_q   <= '0;
            target_q <= '0;
            origin_q <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            dist_q   <= dist_d;
            target_q <= target_d;
            origin_q <= origin_d;
            done_q   <= done_d;
            found_q  <= found_d;
        end
    end

    assign busy     = (st_q == SEEK_RUN);
    assign done     = done_q;
    assign found    = found_q;
    assign distance = dist_q;
    assign origin   = origin_q;
    assign st       = st_q;

endmodule

// File: rtl/lfsr_rewind.sv
// Galois LFSR that steps forward/backward and can seek backward to a target,
// reporting how many draws ago that value was produced.
module lfsr_rewind
    import lfsr_pkg::*;
#(
    parameter int             LEN        = 16,
    parameter logic [LEN-1:0] TAPS       = LFSR_TAPS_DEFAULT,
    parameter int             SEEK_LIMIT = 2**LEN - 1,
    localparam int            DW         = lfsr_dw(SEEK_LIMIT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] seed,
    input  logic           load,
    input  logic           step_fwd,
    input  logic           step_back,
    input  logic           seek_start,
    input  logic [LEN-1:0] seek_target,
    output logic [LEN-1:0] state,
    output logic           busy,
    output logic           done,
    output logic           found,
    output logic [DW-1:0]  distance,
    output seek_st_e       dbg_seek_st
);

    // Commands are single-cycle strobes sampled on each edge. Only one acts
    // per edge (load > seek_start > step_back > step_fwd); while busy only
    // load is honoured. done pulses for one cycle when a seek finishes.
    logic [LEN-1:0] state_q, state_d;
    logic [LEN-1:0] fwd_val, back_val, origin;
    logic           seek_step, seek_restore;

    assign fwd_val  = LEN'(lfsr_fwd(LFSR_MAXW'(state_q), LFSR_MAXW'(TAPS)));
    assign back_val = LEN'(lfsr_back(LFSR_MAXW'(state_q), LFSR_MAXW'(TAPS), LEN));

    lfsr_seek_ctrl #(
        .LEN        (LEN),
        .SEEK_LIMIT (SEEK_LIMIT),
        .DW         (DW)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .seek_start   (seek_start),
        .seek_target  (seek_target),
        .state_q      (state_q),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .distance     (distance),
        .seek_step    (seek_step),
        .seek_restore (seek_restore),
        .origin       (origin),
        .st           (dbg_seek_st)
    );

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (busy) begin
            if (seek_step) begin
                state_d = back_val;
            end else if (seek_restore) begin
                state_d = origin;
            end
        end else if (seek_start) begin
            state_d = state_q;
        end else if (step_back) begin
            state_d = back_val;
        end else if (step_fwd) begin
            state_d = fwd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_lfsr_rewind.sv
// Bench for lfsr_rewind: behavioural model checked every cycle, directed
// literal cases, and randomized walks/commands.
module tb_lfsr_rewind;
    import lfsr_pkg::*;

    localparam logic [15:0] TAPS  = 16'hB400;
    localparam int          LIMIT = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] seed = 16'h0001;
    logic [15:0] seek_target = 16'h0000;
    logic        load = 1'b0, step_fwd = 1'b0, step_back = 1'b0, seek_start = 1'b0;
    logic [15:0] state;
    logic        busy, done, found;
    logic [15:0] distance;
    seek_st_e    dbg_seek_st;

    logic [15:0] seed8 = 16'h0001;
    logic [15:0] seek_target8 = 16'h0000;
    logic        load8 = 1'b0, step_fwd8 = 1'b0, step_back8 = 1'b0, seek_start8 = 1'b0;
    logic [15:0] state8;
    logic        busy8, done8, found8;
    logic [3:0]  distance8;
    seek_st_e    dbg_seek_st8;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    lfsr_rewind dut (
        .clk(clk), .rst(rst), .seed(seed), .load(load), .step_fwd(step_fwd),
        .step_back(step_back), .seek_start(seek_start), .seek_target(seek_target),
        .state(state), .busy(busy), .done(done), .found(found),
        .distance(distance), .dbg_seek_st(dbg_seek_st)
    );

    lfsr_rewind #(.SEEK_LIMIT(8)) dut8 (
        .clk(clk), .rst(rst), .seed(seed8), .load(load8), .step_fwd(step_fwd8),
        .step_back(step_back8), .seek_start(seek_start8), .seek_target(seek_target8),
        .state(state8), .busy(busy8), .done(done8), .found(found8),
        .distance(distance8), .dbg_seek_st(dbg_seek_st8)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_fwd(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] m_back(input logic [15:0] n);
        if (n[15]) return ((n ^ TAPS) << 1) | 16'h0001;
        return n << 1;
    endfunction

    function automatic logic [15:0] m_back_n(input logic [15:0] n, input int k);
        logic [15:0] s;
        s = n;
        for (int i = 0; i < k; i++) s = m_back(s);
        return s;
    endfunction

    // Steps back from start to target; -1 when not within LIMIT steps.
    function automatic int search_dist(input logic [15:0] start, input logic [15:0] target);
        logic [15:0] s;
        s = start;
        for (int i = 0; i <= LIMIT; i++) begin
            if (s == target) return i;
            s = m_back(s);
        end
        return -1;
    endfunction

    logic [15:0] m_state, m_origin, m_dist;
    logic        m_busy, m_done, m_found;
    int          m_sd, m_steps;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= seed;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_found <= 1'b0;
            m_dist  <= 16'h0000;
            m_steps <= 0;
            m_sd    <= 0;
        end else begin
            m_done <= 1'b0;
            if (load) begin
                m_state <= seed;
                m_busy  <= 1'b0;
                m_found <= 1'b0;
            end else if (m_busy) begin
                if (m_steps == ((m_sd < 0) ? LIMIT : m_sd)) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_found <= (m_sd >= 0);
                    m_dist  <= 16'(m_steps);
                    if (m_sd < 0) m_state <= m_origin;
                end else begin
                    m_state <= m_back(m_state);
                    m_steps <= m_steps + 1;
                end
            end else if (seek_start) begin
                m_sd     <= search_dist(m_state, seek_target);
                m_origin <= m_state;
                m_steps  <= 0;
                m_busy   <= 1'b1;
                m_found  <= 1'b0;
            end else if (step_back) begin
                m_state <= m_back(m_state);
            end else if (step_fwd) begin
                m_state <= m_fwd(m_state);
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("state", 32'(state), 32'(m_state));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("found", 32'(found), 32'(m_found));
            check("distance", 32'(distance), 32'(m_dist));
            check("dbg_state", 32'(dbg_seek_st == SEEK_RUN), 32'(m_busy));
            if (done && exp_q.size() > 0) check("sb_distance", 32'(distance), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cmd(input logic l, input logic sf, input logic sb, input logic ss,
                       input logic [15:0] sd, input logic [15:0] tg);
        load = l; step_fwd = sf; step_back = sb; seek_start = ss;
        if (l) seed = sd;
        if (ss) seek_target = tg;
        @(negedge clk);
        load = 1'b0; step_fwd = 1'b0; step_back = 1'b0; seek_start = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] sd);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, sd, 16'h0000);
    endtask

    // Edge numbering: the edge that samples seek_start is edge 1.
    task automatic seek_run(input logic [15:0] tg, input int budget, output int done_edge);
        seek_start = 1'b1; seek_target = tg;
        @(negedge clk);
        seek_start = 1'b0;
        done_edge = -1;
        for (int e = 2; e <= budget; e++) begin
            @(negedge clk);
            if (done) begin
                done_edge = e;
                break;
            end
        end
        if (done_edge < 0) begin
            n_cmp++; n_err++;
            $display("FAIL seek_timeout: no done within %0d edges, required done", budget);
        end
    endtask

    // ---------------- stimulus ----------------
    int          de, k;
    logic [15:0] s;

    initial begin
        rst = 1'b0; seed = 16'h0001; seed8 = 16'h0001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check("rst_state", 32'(state), 32'h0001);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_found", 32'(found), 32'h0);
        check("rst_state8", 32'(state8), 32'h0001);

        cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0); check("fwd1", 32'(state), 32'hB400);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0); check("fwd2", 32'(state), 32'h5A00);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0); check("fwd3", 32'(state), 32'h2D00);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0); check("back1", 32'(state), 32'h5A00);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0); check("back2", 32'(state), 32'hB400);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0); check("back3", 32'(state), 32'h0001);

        do_load(16'h1680);
        exp_q.push_back(16'd4);
        seek_run(16'h0001, 40, de);
        check("seek_edge", 32'(de), 32'd6);
        check("seek_found", 32'(found), 32'h1);
        check("seek_dist", 32'(distance), 32'd4);
        check("seek_state", 32'(state), 32'h0001);

        do_load(16'hACE1);
        exp_q.push_back(16'd0);
        seek_run(16'hACE1, 40, de);
        check("self_edge", 32'(de), 32'd2);
        check("self_dist", 32'(distance), 32'd0);
        check("self_state", 32'(state), 32'hACE1);

        // Abort a seek with load after three backward steps.
        do_load(16'hACE1);
        seek_start = 1'b1; seek_target = 16'h0001;
        @(negedge clk);
        seek_start = 1'b0; step_fwd = 1'b1;
        repeat (3) @(negedge clk);
        step_fwd = 1'b0;
        check("abort_busy", 32'(busy), 32'h1);
        check("abort_walk", 32'(state), 32'(m_back_n(16'hACE1, 3)));
        load = 1'b1; seed = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        check("abort_state", 32'(state), 32'h1234);
        check("abort_busy0", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(negedge clk);
        check("abort_done2", 32'(done), 32'h0);

        // Lock-up state is preserved in both directions.
        do_load(16'h0000);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0); check("zero_fwd", 32'(state), 32'h0);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0); check("zero_back", 32'(state), 32'h0);

        // F then B returns to the start.
        for (int i = 0; i < 1000; i++) begin
            s = 16'($urandom_range(0, 65535));
            do_load(s);
            cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
            cmd(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0);
            check("fb_roundtrip", 32'(state), 32'(s));
        end

        // Forward walk of k steps, then seek back to the start.
        for (int i = 0; i < 30; i++) begin
            s = 16'($urandom_range(1, 65535));
            do_load(s);
            k = $urandom_range(0, 50);
            for (int j = 0; j < k; j++) begin
                cmd(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            exp_q.push_back(16'(k));
            seek_run(s, 120, de);
            check("walk_edge", 32'(de), 32'(k + 2));
            check("walk_found", 32'(found), 32'h1);
            check("walk_state", 32'(state), 32'(s));
        end

        // Random command mix, including simultaneous strobes.
        for (int i = 0; i < 500; i++) begin
            load       = ($urandom_range(0, 19) == 0);
            seek_start = ($urandom_range(0, 9) == 0);
            step_back  = ($urandom_range(0, 2) == 0);
            step_fwd   = ($urandom_range(0, 2) == 0);
            seed       = 16'($urandom_range(1, 65535));
            seek_target = m_back_n(m_state, $urandom_range(0, 20));
            @(negedge clk);
        end
        load = 1'b0; seek_start = 1'b0; step_back = 1'b0; step_fwd = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("mix_idle", 32'(busy), 32'h0);

        // Miss on a small seek limit restores the origin.
        seek_start8 = 1'b1; seek_target8 = 16'h0000;
        @(negedge clk);
        seek_start8 = 1'b0;
        de = -1;
        for (int e = 2; e <= 30; e++) begin
            @(negedge clk);
            if (done8) begin
                de = e;
                break;
            end
        end
        check("miss_edge", 32'(de), 32'd10);
        check("miss_found", 32'(found8), 32'h0);
        check("miss_dist", 32'(distance8), 32'd8);
        check("miss_state", 32'(state8), 32'h0001);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
